regfile_write_arbiter: RTL

Shares the single write port of the 8 x 16 register file among NREQ result producers (ALU, load unit, multi-cycle units) with a per-requester valid/ready handshake and round-robin arbitration. It also keeps a busy scoreboard of destination registers, so issue logic can hold off reads of registers with writes still in flight. It sits between the execution units and the register file write port; its write outputs drive the register file directly.

---
 rtl/regfile_write_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that shares the register file write port among NREQ
// producers, plus a busy scoreboard of destination registers with writes in flight.
// Define REGARB_FIXED_PRIORITY_EN for fixed-priority arbitration (lowest index wins).
module regfile_write_arbiter #(
  parameter int NREQ   = 3,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     rsv_valid,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_ready,
  output logic [(1<<ADDR_W)-1:0]   busy,
  output logic                     write,
  output logic [ADDR_W-1:0]        wrAddr,
  output logic [DATA_W-1:0]        wrData
);

  localparam int NREGS = 1 << ADDR_W;
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;
  logic [NREGS-1:0]  busy_next;

`ifdef REGARB_FIXED_PRIORITY_EN

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_any && req_valid[i]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(i);
      end
    end
  end

`else

  logic [IDX_W-1:0] ptr;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin : rr_search
    int cand;
    cand    = 0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(cand);
      end
    end
  end

  // Pointer moves past the winner only when a grant is actually taken.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (gnt_any) begin
      if (int'(gnt_idx) == NREQ - 1) ptr <= '0;
      else                           ptr <= gnt_idx + IDX_W'(1);
    end
  end

`endif

  // Grant is one-hot and only ever names a valid requester, so valid&ready == gnt_any.
  always_comb begin
    req_ready = '0;
    gnt_addr  = '0;
    gnt_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_any && gnt_idx == IDX_W'(i)) begin
        req_ready[i] = 1'b1;
        gnt_addr     = req_addr[i*ADDR_W +: ADDR_W];
        gnt_data     = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write  <= 1'b0;
      wrAddr <= '0;
      wrData <= '0;
    end else begin
      write <= gnt_any;
      if (gnt_any) begin
        wrAddr <= gnt_addr;
        wrData <= gnt_data;
      end
    end
  end

  assign rsv_ready = rsv_valid & ~busy[rsv_addr];

  // Clear applied before set so a same-edge reservation of the written register survives.
  always_comb begin
    busy_next = busy;
    if (write)     busy_next[wrAddr]   = 1'b0;
    if (rsv_ready) busy_next[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busy_next;
  end

endmodule
